uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_synch2.sv | 28 ++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receiver state encoding and the default bit period. The
// transmitter uses the same BAUD_CYC_DFLT, so both ends of a link built
// from this library agree on the bit rate.
package uart_pkg;

    // Clocks per bit period: 19200 baud from a 50 MHz clock.
    localparam int BAUD_CYC_DFLT = 2604;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_synch2.sv
// synch2 -- two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset; both flops take RST_VAL
//   d      asynchronous input
//   q      synchronized output, two clocks behind d
module synch2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver, LSB first, with sticky error flags.
// Ports:
//   clk      system clock, all state on rising edge
//   rst_n    asynchronous active-low reset
//   RX       asynchronous serial line, idle high
//   clr_rdy  single-cycle acknowledge; clears rdy, frm_err, ovrrn
//   rx_data  last correctly framed byte
//   rdy      new byte available in rx_data
//   frm_err  sticky: a stop bit was sampled low
//   ovrrn    sticky: a byte completed while rdy was still high
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_CYC = BAUD_CYC_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovrrn
);

    localparam int CNT_W = $clog2(BAUD_CYC);
    // The counter expires one clock after reaching zero, so loading N-1
    // gives an interval of exactly N clocks. This also lets the counter
    // stay ceil(log2(BAUD_CYC)) bits wide even when BAUD_CYC is a power of 2.
    localparam logic [CNT_W-1:0] HALF_RLD = CNT_W'(BAUD_CYC / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RLD = CNT_W'(BAUD_CYC - 1);

    logic             rx_s;
    logic             rx_prev;
    rx_state_t        state;
    rx_state_t        nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_ld;
    logic             cnt_exp;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             shift_en;
    logic             stop_good;
    logic             stop_bad;

    synch2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (RX),
        .q     (rx_s)
    );

    assign cnt_exp = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rx_prev <= 1'b1;
        end else begin
            state   <= nxt_state;
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        nxt_state = state;
        cnt_ld    = 1'b0;
        cnt_val   = FULL_RLD;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                // Edge, not level: a held-low line (break) must first go
                // high before another frame can start.
                if (!rx_s && rx_prev) begin
                    cnt_ld    = 1'b1;
                    cnt_val   = HALF_RLD;
                    nxt_state = START;
                end
            end
            START: begin
                if (cnt_exp) begin
                    if (rx_s) begin
                        nxt_state = IDLE;   // glitch, not a start bit
                    end else begin
                        cnt_ld    = 1'b1;
                        nxt_state = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt_exp) begin
                    shift_en = 1'b1;
                    cnt_ld   = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        nxt_state = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_exp) begin
                    nxt_state = IDLE;
                    if (rx_s) begin
                        stop_good = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if (cnt_ld) begin
                cnt <= cnt_val;
            end else if (!cnt_exp) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (state != DATA) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            // LSB arrives first, so after eight shifts it sits in bit 0.
            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end
        end
    end

    // A good completion beats a coincident acknowledge: the new byte is
    // flagged ready, but the acknowledge still clears the error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data <= 8'h00;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            ovrrn   <= 1'b0;
        end else begin
            if (stop_good) begin
                rx_data <= shreg;
            end

            if (stop_good) begin
                rdy <= 1'b1;
            end else if (clr_rdy) begin
                rdy <= 1'b0;
            end

            if (stop_good && rdy && !clr_rdy) begin
                ovrrn <= 1'b1;
            end else if (clr_rdy) begin
                ovrrn <= 1'b0;
            end

            if (stop_bad) begin
                frm_err <= 1'b1;
            end else if (clr_rdy) begin
                frm_err <= 1'b0;
            end
        end
    end

endmodule
